// File: rtl/srt4_pkg.sv
// Shared definitions for the radix-4 SRT divider controller: state
// encoding, datapath strobe bit map, quotient-digit encodings and the
// digit-selection threshold table.
package srt4_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_NORM_CHK,
        S_NORM_SH,
        S_ITER_SH,
        S_QSEL,
        S_APPLY,
        S_CORR_CHK,
        S_CORRECT,
        S_DENORM_CHK,
        S_DENORM_SH,
        S_OUT_Q,
        S_OUT_R,
        S_DONE
    } state_t;

    // Width of the datapath strobe vector and the position of each strobe.
    localparam int CTRL_W    = 12;
    localparam int LD_A      = 0;
    localparam int LD_B      = 1;
    localparam int NORM_SH   = 2;
    localparam int SH_P      = 3;   // P,A shifted left by two
    localparam int Q_WR      = 4;
    localparam int SEL_2B    = 5;
    localparam int ADD_EN    = 6;
    localparam int SUB       = 7;
    localparam int CORR      = 8;   // P += B, Q -= 1
    localparam int DENORM_SH = 9;   // P >> 1
    localparam int OUT_Q     = 10;
    localparam int OUT_R     = 11;

    // Quotient digits, three-bit two's complement.
    localparam logic [2:0] D_N2 = 3'b110;
    localparam logic [2:0] D_N1 = 3'b111;
    localparam logic [2:0] D_Z  = 3'b000;
    localparam logic [2:0] D_P1 = 3'b001;
    localparam logic [2:0] D_P2 = 3'b010;

    // Lower bound of the shifted partial remainder (p_top, units of 1/4)
    // for selecting digit k, indexed by the divisor fraction b_top
    // (divisor = 1.b_top). Thresholds sit inside the overlap regions of the
    // minimally redundant radix-4 P-D plot: m2 ~ 6d, m1 ~ 2d, m0 ~ -2d,
    // m-1 ~ -6d.
    localparam logic signed [5:0] QSEL_M [-1:2][0:15] = '{
        '{-6'sd6, -6'sd6, -6'sd7, -6'sd7, -6'sd8, -6'sd8, -6'sd8, -6'sd9,
          -6'sd9, -6'sd9, -6'sd10, -6'sd10, -6'sd11, -6'sd11, -6'sd11, -6'sd12},
        '{-6'sd2, -6'sd2, -6'sd2, -6'sd2, -6'sd3, -6'sd3, -6'sd3, -6'sd3,
          -6'sd3, -6'sd3, -6'sd3, -6'sd3, -6'sd4, -6'sd4, -6'sd4, -6'sd4},
        '{6'sd2, 6'sd2, 6'sd2, 6'sd2, 6'sd3, 6'sd3, 6'sd3, 6'sd3,
          6'sd3, 6'sd3, 6'sd3, 6'sd3, 6'sd4, 6'sd4, 6'sd4, 6'sd4},
        '{6'sd6, 6'sd6, 6'sd7, 6'sd7, 6'sd8, 6'sd8, 6'sd8, 6'sd9,
          6'sd9, 6'sd9, 6'sd10, 6'sd10, 6'sd11, 6'sd11, 6'sd11, 6'sd12}
    };

    // Moore strobe decode: strobes for a state, given the digit held in it.
    function automatic logic [CTRL_W-1:0] ctrl_for(input state_t s, input logic [2:0] qd);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (s)
            S_LOAD_A:    c[LD_A] = 1'b1;
            S_LOAD_B:    c[LD_B] = 1'b1;
            S_NORM_SH:   c[NORM_SH] = 1'b1;
            S_ITER_SH:   c[SH_P] = 1'b1;
            S_APPLY: begin
                c[Q_WR]   = 1'b1;
                c[ADD_EN] = (qd != D_Z);
                c[SEL_2B] = (qd == D_P2) || (qd == D_N2);
                c[SUB]    = (qd == D_P1) || (qd == D_P2);
            end
            S_CORRECT:   c[CORR] = 1'b1;
            S_DENORM_SH: c[DENORM_SH] = 1'b1;
            S_OUT_Q:     c[OUT_Q] = 1'b1;
            S_OUT_R:     c[OUT_R] = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/srt4_div_ctrl_qsel.sv
// Radix-4 SRT quotient-digit selection: picks the largest digit whose
// threshold the signed partial-remainder estimate reaches, else -2.
module srt4_qsel
    import srt4_pkg::*;
(
    input  logic [3:0] b_top,
    input  logic [5:0] p_top,
    output logic [2:0] digit
);

    // Threshold compares, highest digit checked last so it wins.
    always_comb begin
        digit = D_N2;
        if ($signed(p_top) >= QSEL_M[-1][b_top]) digit = D_N1;
        if ($signed(p_top) >= QSEL_M[0][b_top])  digit = D_Z;
        if ($signed(p_top) >= QSEL_M[1][b_top])  digit = D_P1;
        if ($signed(p_top) >= QSEL_M[2][b_top])  digit = D_P2;
    end

endmodule

// File: rtl/srt4_div_ctrl.sv
// Control unit for the radix-4 SRT sequential divider. Sequences load,
// divisor normalisation, WIDTH/2 digit iterations, remainder correction,
// denormalisation and write-out.
// Optional feature macro: SRT4_DIVZERO_EN (early exit on a zero divisor).
//
// Handshake: start is a level request sampled only in IDLE (ignored while
// busy); done is a one-cycle pulse in DONE, after which the unit returns to
// IDLE and may accept a new start on the following edge. All outputs are
// registered and depend only on the state and the held quotient digit.
module srt4_div_ctrl
    import srt4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              b_msb,
    input  logic [3:0]        b_top,
    input  logic [5:0]        p_top,
    input  logic              p_sign,
    input  logic              b_zero,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [2:0]        q_digit,
    output logic [CTRL_W-1:0] ctrl
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] NMAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] IMAX = CW'(ITER - 1);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] ncnt;
    logic [CW-1:0] icnt;
    logic [2:0]    sel_digit;
    logic [2:0]    qd_nxt;

    srt4_qsel u_qsel (
        .b_top (b_top),
        .p_top (p_top),
        .digit (sel_digit)
    );

`ifndef SRT4_DIVZERO_EN
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
`endif

    // Next-state decode and the digit that will be held in the next state.
    always_comb begin
        nxt    = state;
        qd_nxt = (state == S_QSEL) ? sel_digit : q_digit;
        case (state)
            S_IDLE:       if (start) nxt = S_LOAD_A;
            S_LOAD_A:     nxt = S_LOAD_B;
`ifdef SRT4_DIVZERO_EN
            S_LOAD_B:     nxt = b_zero ? S_DONE : S_NORM_CHK;
`else
            S_LOAD_B:     nxt = S_NORM_CHK;
`endif
            S_NORM_CHK:   nxt = (b_msb || ncnt == NMAX) ? S_ITER_SH : S_NORM_SH;
            S_NORM_SH:    nxt = S_NORM_CHK;
            S_ITER_SH:    nxt = S_QSEL;
            S_QSEL:       nxt = S_APPLY;
            S_APPLY:      nxt = (icnt == IMAX) ? S_CORR_CHK : S_ITER_SH;
            S_CORR_CHK:   nxt = p_sign ? S_CORRECT : S_DENORM_CHK;
            S_CORRECT:    nxt = S_DENORM_CHK;
            S_DENORM_CHK: nxt = (ncnt == '0) ? S_OUT_Q : S_DENORM_SH;
            S_DENORM_SH:  nxt = S_DENORM_CHK;
            S_OUT_Q:      nxt = S_OUT_R;
            S_OUT_R:      nxt = S_DONE;
            S_DONE:       nxt = S_IDLE;
            default:      nxt = S_IDLE;
        endcase
    end

    // State, counters and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_IDLE;
            ncnt     <= '0;
            icnt     <= '0;
            q_digit  <= D_Z;
            ctrl     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state   <= nxt;
            q_digit <= qd_nxt;
            ctrl    <= ctrl_for(nxt, qd_nxt);
            busy    <= (nxt != S_IDLE);
            done    <= (nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ncnt     <= '0;
                        icnt     <= '0;
                        div_zero <= 1'b0;
                    end
                end
`ifdef SRT4_DIVZERO_EN
                S_LOAD_B: begin
                    if (b_zero) div_zero <= 1'b1;
                end
`endif
                S_NORM_SH: begin
                    if (ncnt != NMAX) ncnt <= ncnt + 1'b1;
                end
                S_DENORM_SH: begin
                    if (ncnt != '0) ncnt <= ncnt - 1'b1;
                end
                S_APPLY: begin
                    if (icnt != IMAX) icnt <= icnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_srt4_div_ctrl.sv
// Directed bench for srt4_div_ctrl (WIDTH=8): latency, strobe counts,
// digit selection, zero-divisor handling, start hold-off and async abort.
module tb_srt4_div_ctrl;

    localparam int B_LD_A      = 0;
    localparam int B_LD_B      = 1;
    localparam int B_NORM_SH   = 2;
    localparam int B_SH_P      = 3;
    localparam int B_Q_WR      = 4;
    localparam int B_SEL_2B    = 5;
    localparam int B_ADD_EN    = 6;
    localparam int B_SUB       = 7;
    localparam int B_CORR      = 8;
    localparam int B_DENORM_SH = 9;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic        b_msb;
    logic [3:0]  b_top;
    logic [5:0]  p_top;
    logic        p_sign;
    logic        b_zero;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [2:0]  q_digit;
    logic [11:0] ctrl;

    int errors = 0;
    int checks = 0;

    // Per-operation observations.
    int          r_done, r_lda, r_ldb, r_norm, r_denorm, r_corr, r_shp, r_qwr;
    int          r_add, r_sel, r_sub, r_bad_triple, r_busy_bad, r_last_shp;
    logic [2:0]  r_dig;
    logic        r_dz, r_idle_busy, r_idle_dz, r_restart;
    logic [11:0] r_ctrl_or;

    srt4_div_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .b_msb    (b_msb),
        .b_top    (b_top),
        .p_top    (p_top),
        .p_sign   (p_sign),
        .b_zero   (b_zero),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .q_digit  (q_digit),
        .ctrl     (ctrl)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one operation. b_msb is modelled by a datapath stub that rises
    // after k normalisation shifts have been observed.
    task automatic run_op(input int k, input logic ps, input logic [5:0] pt,
                          input logic bz, input bit hold);
        int cyc;
        int nseen;
        nseen = 0;
        b_msb = (k == 0); p_sign = ps; p_top = pt; b_zero = bz; b_top = 4'd0;
        r_done = -1; r_lda = -1; r_ldb = -1; r_norm = 0; r_denorm = 0; r_corr = 0;
        r_shp = 0; r_qwr = 0; r_add = 0; r_sel = 0; r_sub = 0; r_bad_triple = 0;
        r_busy_bad = 0; r_last_shp = -10; r_dig = 3'b000; r_dz = 1'b0;
        r_ctrl_or = '0; r_restart = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 if (!hold) start = 1'b0;
        cyc = 0;
        while (r_done < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            r_ctrl_or |= ctrl;
            if (ctrl[B_LD_A]) r_lda = cyc;
            if (ctrl[B_LD_B]) r_ldb = cyc;
            if (ctrl[B_NORM_SH]) begin r_norm++; nseen++; end
            b_msb = (nseen >= k);
            if (ctrl[B_DENORM_SH]) r_denorm++;
            if (ctrl[B_CORR]) r_corr++;
            if (ctrl[B_SH_P]) begin r_shp++; r_last_shp = cyc; end
            if (ctrl[B_Q_WR]) begin
                r_qwr++;
                if (cyc != r_last_shp + 2) r_bad_triple++;
                r_add += int'(ctrl[B_ADD_EN]);
                r_sel += int'(ctrl[B_SEL_2B]);
                r_sub += int'(ctrl[B_SUB]);
                r_dig = q_digit;
            end
            if (!busy) r_busy_bad++;
            if (done) begin r_done = cyc; r_dz = div_zero; end
        end
        @(negedge clk);
        r_idle_busy = busy;
        r_idle_dz   = div_zero;
        if (hold) begin
            @(negedge clk);
            r_restart = ctrl[B_LD_A];
            start = 1'b0;
            cyc = 0;
            while (!done && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int seen;
        rst_b = 1'b0; start = 1'b0; b_msb = 1'b1; b_top = 4'd0;
        p_top = 6'd0; p_sign = 1'b0; b_zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", ctrl, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_qdig", q_digit, 0);
        check("reset_dz", div_zero, 0);
        rst_b = 1'b1;
        @(negedge clk);

        // Normalised divisor, zero digits.
        run_op(0, 1'b0, 6'd0, 1'b0, 1'b0);
        check("base_lda_cyc", r_lda, 1);
        check("base_ldb_cyc", r_ldb, 2);
        check("base_done_cyc", r_done, 20);
        check("base_norm", r_norm, 0);
        check("base_denorm", r_denorm, 0);
        check("base_shp", r_shp, 4);
        check("base_qwr", r_qwr, 4);
        check("base_add", r_add, 0);
        check("base_triple", r_bad_triple, 0);
        check("base_corr", r_corr, 0);
        check("base_busy", r_busy_bad, 0);
        check("base_idle_busy", r_idle_busy, 0);
        check("base_dz", r_dz, 0);

        // Three normalisation shifts.
        run_op(3, 1'b0, 6'd0, 1'b0, 1'b0);
        check("norm3_norm", r_norm, 3);
        check("norm3_denorm", r_denorm, 3);
        check("norm3_done_cyc", r_done, 32);

        // Remainder correction.
        run_op(0, 1'b1, 6'd0, 1'b0, 1'b0);
        check("corr_count", r_corr, 1);
        check("corr_done_cyc", r_done, 21);

        // Digit +2.
        run_op(0, 1'b0, 6'b011111, 1'b0, 1'b0);
        check("p2_digit", r_dig, 3'b010);
        check("p2_add", r_add, 4);
        check("p2_sel", r_sel, 4);
        check("p2_sub", r_sub, 4);
        check("p2_done_cyc", r_done, 20);

        // Digit -2.
        run_op(0, 1'b0, 6'b100000, 1'b0, 1'b0);
        check("n2_digit", r_dig, 3'b110);
        check("n2_add", r_add, 4);
        check("n2_sel", r_sel, 4);
        check("n2_sub", r_sub, 0);

        // Digit +1 (p=3, threshold m1=2, m2=6 at b_top=0).
        run_op(0, 1'b0, 6'b000011, 1'b0, 1'b0);
        check("p1_digit", r_dig, 3'b001);
        check("p1_sel", r_sel, 0);
        check("p1_sub", r_sub, 4);

        // Digit -1 (p=-3, thresholds m0=-2, m-1=-6).
        run_op(0, 1'b0, 6'b111101, 1'b0, 1'b0);
        check("n1_digit", r_dig, 3'b111);
        check("n1_add", r_add, 4);
        check("n1_sub", r_sub, 0);

        // Zero divisor.
        run_op(100, 1'b0, 6'd0, 1'b1, 1'b0);
`ifdef SRT4_DIVZERO_EN
        check("dz_done_cyc", r_done, 3);
        check("dz_flag", r_dz, 1);
        check("dz_flag_hold", r_idle_dz, 1);
        check("dz_strobes", r_ctrl_or, 12'h003);
`else
        check("bz_norm", r_norm, 7);
        check("bz_denorm", r_denorm, 7);
        check("bz_done_cyc", r_done, 48);
        check("bz_flag", r_dz, 0);
`endif

        // Start held through DONE restarts only after IDLE.
        run_op(0, 1'b0, 6'd0, 1'b0, 1'b1);
        check("hold_done_cyc", r_done, 20);
        check("hold_dz_clear", r_dz, 0);
        check("hold_idle_busy", r_idle_busy, 0);
        check("hold_restart", r_restart, 1);

        // Abort during the second APPLY.
        b_msb = 1'b1; p_top = 6'b011111; p_sign = 1'b0; b_zero = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; seen = 0;
        while (seen < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ctrl[B_Q_WR]) seen++;
        end
        check("abort_reached", seen, 2);
        #1 rst_b = 1'b0;
        #1;
        check("abort_ctrl", ctrl, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_qdig", q_digit, 0);
        @(negedge clk) rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_quiet", ctrl, 0);
        run_op(0, 1'b0, 6'd0, 1'b0, 1'b0);
        check("abort_next_done", r_done, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
